// File: rtl/pe16_pkg.sv
// Shared widths, types and the sign/magnitude to two's-complement helper
// for the 16-lane PE alignment datapath.
package pe16_pkg;
    localparam int LANES  = 16;
    localparam int WIDTH  = 52;
    localparam int EXP_W  = 10;
    localparam int GROUPS = LANES / 4;

    typedef logic        [EXP_W-1:0] exp_t;
    typedef logic        [WIDTH-1:0] mag_t;
    typedef logic signed [WIDTH:0]   sdata_t;

    // Shifting right by WIDTH already leaves only sign bits in a WIDTH+1 word.
    localparam exp_t SHIFT_SAT = exp_t'(WIDTH);

    // Zero-extension before negation keeps -0 at 0 and leaves no overflow case.
    function automatic sdata_t to_sdata(input logic sign, input mag_t mag);
        sdata_t u;
        u = sdata_t'({1'b0, mag});
        return sign ? -u : u;
    endfunction
endpackage

// File: rtl/exp_max4.sv
// Combinational unsigned maximum of four exponents (two levels of the max tree).
module exp_max4
    import pe16_pkg::*;
(
    input  exp_t a,
    input  exp_t b,
    input  exp_t c,
    input  exp_t d,
    output exp_t y
);
    exp_t ab;
    exp_t cd;

    assign ab = (a > b) ? a : b;
    assign cd = (c > d) ? c : d;
    assign y  = (ab > cd) ? ab : cd;
endmodule

// File: rtl/align_shift_gen.sv
// Four-stage valid/ready pipeline: converts lane magnitudes to two's complement,
// finds the beat's maximum exponent and emits saturated per-lane right-shift amounts.
module align_shift_gen
    import pe16_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             in_sign,
    input  logic [LANES*EXP_W-1:0]       in_exp,
    input  logic [LANES*WIDTH-1:0]       in_mag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*(WIDTH+1)-1:0]   odata,
    output logic [LANES*EXP_W-1:0]       oshift,
    output logic [EXP_W-1:0]             omax_exp
);
    logic   v1, v2, v3, v4;
    logic   adv1, adv2, adv3, adv4;

    sdata_t d1 [LANES];
    sdata_t d2 [LANES];
    sdata_t d3 [LANES];
    sdata_t d4 [LANES];
    exp_t   e1 [LANES];
    exp_t   e2 [LANES];
    exp_t   e3 [LANES];
    exp_t   sh4 [LANES];
    exp_t   sh_c [LANES];
    exp_t   gmax_c [GROUPS];
    exp_t   gmax2 [GROUPS];
    exp_t   max_c;
    exp_t   max3;
    exp_t   max4;

    // Each stage moves when it is empty or its successor is moving.
    assign adv4      = !v4 || out_ready;
    assign adv3      = !v3 || adv4;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v4;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        exp_max4 u_grp (
            .a(e1[4*g]), .b(e1[4*g+1]), .c(e1[4*g+2]), .d(e1[4*g+3]),
            .y(gmax_c[g])
        );
    end

    exp_max4 u_top (
        .a(gmax2[0]), .b(gmax2[1]), .c(gmax2[2]), .d(gmax2[3]),
        .y(max_c)
    );

    // Valid chain; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
            if (adv4) v4 <= v3;
        end
    end

    // S1: capture exponents and signed lane values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                e1[i] <= '0;
                d1[i] <= '0;
            end
        end else if (adv1) begin
            for (int i = 0; i < LANES; i++) begin
                e1[i] <= in_exp[i*EXP_W +: EXP_W];
                d1[i] <= to_sdata(in_sign[i], in_mag[i*WIDTH +: WIDTH]);
            end
        end
    end

    // S2: group maxima, payload carried along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                e2[i] <= '0;
                d2[i] <= '0;
            end
            for (int g = 0; g < GROUPS; g++) gmax2[g] <= '0;
        end else if (adv2) begin
            for (int i = 0; i < LANES; i++) begin
                e2[i] <= e1[i];
                d2[i] <= d1[i];
            end
            for (int g = 0; g < GROUPS; g++) gmax2[g] <= gmax_c[g];
        end
    end

    // S3: beat maximum exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                e3[i] <= '0;
                d3[i] <= '0;
            end
            max3 <= '0;
        end else if (adv3) begin
            for (int i = 0; i < LANES; i++) begin
                e3[i] <= e2[i];
                d3[i] <= d2[i];
            end
            max3 <= max_c;
        end
    end

    // Shift = distance below the max; exp_i <= max3 so the difference never wraps.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sh_c[i] = max3 - e3[i];
            if (sh_c[i] > SHIFT_SAT) sh_c[i] = SHIFT_SAT;
        end
    end

    // S4: output registers, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                d4[i]  <= '0;
                sh4[i] <= '0;
            end
            max4 <= '0;
        end else if (adv4) begin
            for (int i = 0; i < LANES; i++) begin
                d4[i]  <= d3[i];
                sh4[i] <= sh_c[i];
            end
            max4 <= max3;
        end
    end

    // Flatten lane arrays onto the output buses.
    always_comb begin
        odata  = '0;
        oshift = '0;
        for (int i = 0; i < LANES; i++) begin
            odata[i*(WIDTH+1) +: WIDTH+1] = d4[i];
            oshift[i*EXP_W +: EXP_W]      = sh4[i];
        end
        omax_exp = max4;
    end
endmodule

// File: tb/tb_align_shift_gen.sv
// Directed and randomized bench for align_shift_gen with a queue-based reference model.
module tb_align_shift_gen;
    localparam int L  = 16;
    localparam int W  = 52;
    localparam int EW = 10;
    localparam int DW = L * (W + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [L-1:0]      in_sign = '0;
    logic [L*EW-1:0]   in_exp = '0;
    logic [L*W-1:0]    in_mag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     odata;
    logic [L*EW-1:0]   oshift;
    logic [EW-1:0]     omax_exp;

    typedef struct {
        logic [DW-1:0]   d;
        logic [L*EW-1:0] s;
        logic [EW-1:0]   m;
        int              acc_cyc;
    } beat_t;

    beat_t           q[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              emitted = 0;
    bit              lat_exact = 0;
    bit              prev_stall = 0;
    logic [DW-1:0]   hold_d, last_d;
    logic [L*EW-1:0] hold_s, last_s;
    logic [EW-1:0]   hold_m, last_m;

    align_shift_gen dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready),
        .odata(odata), .oshift(oshift), .omax_exp(omax_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: max over lanes, distance below it capped at W, signed value by arithmetic.
    function automatic beat_t model();
        beat_t  b;
        int     mx;
        int     sh;
        longint v;
        mx = 0;
        for (int i = 0; i < L; i++)
            if (int'(in_exp[i*EW +: EW]) > mx) mx = int'(in_exp[i*EW +: EW]);
        b.d = '0;
        b.s = '0;
        b.m = EW'(mx);
        for (int i = 0; i < L; i++) begin
            sh = mx - int'(in_exp[i*EW +: EW]);
            if (sh > W) sh = W;
            b.s[i*EW +: EW] = EW'(sh);
            v = longint'(in_mag[i*W +: W]);
            if (in_sign[i]) v = -v;
            b.d[i*(W+1) +: W+1] = v[W:0];
        end
        b.acc_cyc = 0;
        return b;
    endfunction

    task automatic step(output bit acc);
        beat_t b;
        #1;
        acc = in_valid && in_ready;
        if (prev_stall) begin
            chk("stall_odata", odata, hold_d);
            chk("stall_oshift", oshift, hold_s);
            chk("stall_omax", omax_exp, hold_m);
        end
        if (out_valid && out_ready) begin
            chk("out_has_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                b = q.pop_front();
                chk("odata", odata, b.d);
                chk("oshift", oshift, b.s);
                chk("omax_exp", omax_exp, b.m);
                if (lat_exact) chk("latency", cyc - b.acc_cyc, 4);
                else chk("latency_min", (cyc - b.acc_cyc) >= 4, 1);
                last_d = odata;
                last_s = oshift;
                last_m = omax_exp;
                emitted++;
            end
        end
        if (acc) begin
            b = model();
            b.acc_cyc = cyc;
            q.push_back(b);
        end
        prev_stall = out_valid && !out_ready;
        hold_d = odata;
        hold_s = oshift;
        hold_m = omax_exp;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_beat(input int mode);
        logic [63:0] r;
        int          base;
        base = $urandom_range(0, 900);
        for (int i = 0; i < L; i++) begin
            in_sign[i] = 1'($urandom_range(0, 1));
            r = {$urandom(), $urandom()};
            in_mag[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : r[W-1:0];
            if (mode == 0) in_exp[i*EW +: EW] = EW'($urandom_range(0, 1023));
            else           in_exp[i*EW +: EW] = EW'(base + $urandom_range(0, 60));
        end
    endtask

    task automatic send_beat();
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        chk("send_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 100) begin
            step(acc);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        bit acc;
        int k;
        int n;
        bit saw_full;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_odata", odata, 0);
        chk("rst_oshift", oshift, 0);
        chk("rst_omax", omax_exp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Test 1: ascending exponents
        for (int i = 0; i < L; i++) begin
            in_exp[i*EW +: EW] = EW'(100 + i);
            in_mag[i*W +: W] = W'(1);
            in_sign[i] = 1'b0;
        end
        send_beat();
        drain();
        chk("t1_omax", last_m, 115);
        for (int i = 0; i < L; i++) begin
            chk("t1_shift", last_s[i*EW +: EW], 15 - i);
            chk("t1_data", last_d[i*(W+1) +: W+1], 1);
        end

        // Test 2: one dominant exponent, saturation, negative lane
        for (int i = 0; i < L; i++) begin
            in_exp[i*EW +: EW] = (i == 0) ? EW'(1000) : EW'(10);
            in_mag[i*W +: W] = (i == 3) ? W'(5) : W'(1);
            in_sign[i] = (i == 3);
        end
        send_beat();
        drain();
        chk("t2_shift0", last_s[0 +: EW], 0);
        for (int i = 1; i < L; i++) chk("t2_shift_sat", last_s[i*EW +: EW], 52);
        chk("t2_data3", last_d[3*(W+1) +: W+1], 53'h1F_FFFF_FFFF_FFFB);

        // Test 3: negative zeros, equal exponents
        for (int i = 0; i < L; i++) begin
            in_exp[i*EW +: EW] = EW'(37);
            in_mag[i*W +: W] = '0;
            in_sign[i] = 1'b1;
        end
        send_beat();
        drain();
        chk("t3_omax", last_m, 37);
        chk("t3_oshift", last_s, 0);
        chk("t3_odata", last_d, 0);

        // Test 4: back-pressure with 8 streamed beats
        emitted = 0;
        out_ready = 1'b0;
        k = 0;
        n = 0;
        saw_full = 0;
        while (k < 8 && n < 200) begin
            rand_beat(k % 2);
            in_valid = 1'b1;
            if (n == 10) out_ready = 1'b1;
            #1;
            if (!in_ready && !saw_full) begin
                saw_full = 1;
                chk("t4_full_at_4", k, 4);
            end
            #0;
            step(acc);
            if (acc) k++;
            n++;
        end
        chk("t4_sent", k, 8);
        chk("t4_saw_full", saw_full, 1);
        drain();
        chk("t4_count", emitted, 8);

        // Test 5: continuous throughput and exact latency
        lat_exact = 1;
        emitted = 0;
        out_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            rand_beat(b % 2);
            in_valid = 1'b1;
            #1;
            chk("t5_in_ready", in_ready, 1);
            step(acc);
        end
        in_valid = 1'b0;
        chk("t5_first_after_4", emitted, 16);
        drain();
        chk("t5_count", emitted, 20);

        // Test 6: asynchronous reset mid-stream
        for (int b = 0; b < 5; b++) begin
            rand_beat(1);
            in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        #1;
        chk("t6_pre_out_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_odata", odata, 0);
        chk("t6_rst_oshift", oshift, 0);
        chk("t6_rst_omax", omax_exp, 0);
        q.delete();
        prev_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t6_no_stale", out_valid, 0);
            step(acc);
        end
        emitted = 0;
        rand_beat(0);
        send_beat();
        drain();
        chk("t6_count", emitted, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
